// File: rtl/uart1_transmitter.sv
// uart1_transmitter: single-channel UART serial transmitter.
// Captures data_in plus caller-supplied start/stop bit values on a load
// strobe, then shifts the frame out LSB-first on the registered line tx1.
// Ports:
//   clk                - system clock, rising edge
//   rst                - asynchronous reset, active low
//   load               - capture a new frame (honoured only when idle)
//   start_bit          - value driven during the start-bit slot
//   data_in            - parallel payload, bit 0 sent first
//   stop_bit           - value driven during the stop-bit slot
//   tx1                - serial line, registered, idles high
//   parallel_in_active - 1 when idle and a load will be accepted
module uart1_transmitter #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 start_bit,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 stop_bit,
  output logic                 tx1,
  output logic                 parallel_in_active
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);

  localparam logic [BW-1:0] BAUD_LAST =
    BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] BIT_LAST =
    IW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e               state_q;
  state_e               state_d;
  logic [BW-1:0]        baud_q;
  logic [BW-1:0]        baud_d;
  logic [IW-1:0]        bit_q;
  logic [IW-1:0]        bit_d;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic                 start_q;
  logic                 start_d;
  logic                 stop_q;
  logic                 stop_d;
  logic                 tx_q;
  logic                 tx_d;
  logic                 bit_end;

  assign bit_end = (baud_q == BAUD_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      start_q <= 1'b0;
      stop_q  <= 1'b1;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    start_d = start_q;
    stop_d  = stop_q;

    unique case (state_q)
      S_IDLE: begin
        if (load) begin
          state_d = S_START;
          baud_d  = '0;
          bit_d   = '0;
          shift_d = data_in;
          start_d = start_bit;
          stop_d  = stop_bit;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = S_STOP;
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + IW'(1);
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Line value follows the next state so tx1 changes on the
  // same edge that enters each slot.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      S_IDLE:  tx_d = 1'b1;
      S_START: tx_d = start_d;
      S_DATA:  tx_d = shift_d[0];
      S_STOP:  tx_d = stop_d;
      default: tx_d = 1'b1;
    endcase
  end

  assign tx1                = tx_q;
  assign parallel_in_active = (state_q == S_IDLE);

endmodule

// File: tb/tb_uart1_transmitter.sv
// tb_uart1_transmitter: scoreboard bench for uart1_transmitter.
// Expected frames are queued on load and checked by a line monitor.
module tb_uart1_transmitter;

  localparam int CPB   = 4;
  localparam int DB    = 8;
  localparam int FBITS = DB + 2;
  localparam int FLEN  = FBITS * CPB;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load = 1'b0;
  logic          start_bit = 1'b0;
  logic [DB-1:0] data_in = '0;
  logic          stop_bit = 1'b1;
  logic          tx1;
  logic          parallel_in_active;

  logic [FBITS-1:0] q[$];
  int errors = 0;
  int checks = 0;
  int frames = 0;
  int pushed = 0;
  int aborted = 0;

  uart1_transmitter #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS(DB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load(load),
    .start_bit(start_bit),
    .data_in(data_in),
    .stop_bit(stop_bit),
    .tx1(tx1),
    .parallel_in_active(parallel_in_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic push(input logic [DB-1:0] d,
                      input logic sb,
                      input logic pb);
    q.push_back({pb, d, sb});
    pushed++;
  endtask

  task automatic load_frame(input logic [DB-1:0] d,
                            input logic sb,
                            input logic pb);
    @(negedge clk);
    data_in   = d;
    start_bit = sb;
    stop_bit  = pb;
    load      = 1'b1;
    push(d, sb, pb);
    @(posedge clk);
    #1;
    check("load_busy", 32'(parallel_in_active), 0);
    check("load_tx", 32'(tx1), 32'(sb));
    load = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (q.size() == 0 && parallel_in_active) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  // Line monitor: a frame begins at the first negedge that
  // shows the transmitter busy.
  initial begin : mon
    logic [FBITS-1:0] got;
    int unstable;
    int low_bad;
    bit abort;
    forever begin
      @(negedge clk);
      if (rst && !parallel_in_active) begin
        got = '0;
        unstable = 0;
        low_bad = 0;
        abort = 1'b0;
        for (int k = 0; k < FLEN; k++) begin
          if (k > 0) @(negedge clk);
          if (!rst) begin
            abort = 1'b1;
            break;
          end
          if (parallel_in_active) low_bad++;
          if (k % CPB == 0) got[k / CPB] = tx1;
          else if (tx1 !== got[k / CPB]) unstable++;
        end
        if (abort) begin
          aborted++;
          if (q.size() > 0) void'(q.pop_front());
        end else begin
          @(negedge clk);
          check("idle_after", {parallel_in_active, tx1}, 2'b11);
          check("busy_len", low_bad, 0);
          check("bit_stable", unstable, 0);
          if (q.size() == 0) begin
            check("unexpected_frame", 1, 0);
          end else begin
            check("frame", got, q.pop_front());
          end
          frames++;
        end
      end
    end
  end

  initial begin : stim
    // 1: reset held with load toggling
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      load = i[0];
      #1;
      check("rst_tx", 32'(tx1), 1);
      check("rst_idle", 32'(parallel_in_active), 1);
    end
    @(negedge clk);
    load = 1'b0;
    rst  = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_tx", 32'(tx1), 1);
    check("post_rst_idle", 32'(parallel_in_active), 1);

    // 2: basic frame
    load_frame(8'hA5, 1'b0, 1'b1);
    wait_idle(100);

    // 3: load while busy is ignored
    load_frame(8'h3C, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    data_in = 8'hFF;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_idle(100);
    repeat (8) @(negedge clk);
    check("no_extra", 32'(parallel_in_active), 1);

    // 4: back-to-back with load held high
    @(negedge clk);
    data_in   = 8'h00;
    start_bit = 1'b0;
    stop_bit  = 1'b1;
    load      = 1'b1;
    push(8'h00, 1'b0, 1'b1);
    push(8'hFF, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("b2b_first", 32'(parallel_in_active), 0);
    @(negedge clk);
    data_in = 8'hFF;
    repeat (40) @(posedge clk);
    #1;
    check("b2b_gap", {parallel_in_active, tx1}, 2'b11);
    @(posedge clk);
    #1;
    check("b2b_second", {parallel_in_active, tx1}, 2'b00);
    load = 1'b0;
    wait_idle(100);

    // 5: asynchronous reset during data bit 3
    @(negedge clk);
    data_in   = 8'h53;
    start_bit = 1'b0;
    stop_bit  = 1'b1;
    load      = 1'b1;
    push(8'h53, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    load = 1'b0;
    repeat (16) @(posedge clk);
    #2;
    check("bit3_val", 32'(tx1), 0);
    rst = 1'b0;
    #1;
    check("abort_tx", 32'(tx1), 1);
    check("abort_idle", 32'(parallel_in_active), 1);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    load_frame(8'h96, 1'b0, 1'b1);
    wait_idle(100);

    // 6: non-standard framing sent verbatim
    load_frame(8'h01, 1'b1, 1'b0);
    wait_idle(100);

    repeat (4) @(negedge clk);
    check("frame_count", frames, pushed - aborted);
    check("aborted", aborted, 1);
    check("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
